dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_pkg.sv | 25 ++
 rtl/dds_step_calc.sv | 32 +++
 rtl/dds_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller and its helpers.
package dds_pkg;

  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_DWELL_WIDTH = 24;

  typedef enum logic [1:0] {
    WAVE_SIN = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SAW = 2'd2,
    WAVE_SQR = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweep_dir_e;

endpackage

// File: rtl/dds_step_calc.sv
// Next sweep point, clamped to the stop word on overshoot, carry/borrow or zero step.
// Purely combinational; no handshake.
module dds_step_calc
  import dds_pkg::*;
#(
  parameter int W = DEF_PHASE_WIDTH
) (
  input  logic [W-1:0] cur_word,
  input  logic [W-1:0] step_word,
  input  logic [W-1:0] stop_word,
  input  sweep_dir_e   dir,
  output logic [W-1:0] next_word
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum       = {1'b0, cur_word} + {1'b0, step_word};
    diff      = {1'b0, cur_word} - {1'b0, step_word};
    next_word = stop_word;
    // A zero step would never reach stop, so it jumps straight there.
    if (step_word != '0) begin
      if (dir == DIR_UP) begin
        if (!sum[W] && (sum[W-1:0] <= stop_word)) next_word = sum[W-1:0];
      end else begin
        if (!diff[W] && (diff[W-1:0] >= stop_word)) next_word = diff[W-1:0];
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller: command accepted in IDLE, outputs registered one cycle later,
// each point held dwell+1 cycles; cfg_ready low outside IDLE is the only backpressure.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_start_word,
  input  logic [PHASE_WIDTH-1:0] cfg_stop_word,
  input  logic [PHASE_WIDTH-1:0] cfg_step_word,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [PHASE_WIDTH-1:0] cfg_pha_word,
  input  logic [1:0]             cfg_wave_type,
  input  logic                   cfg_loop,
  input  logic                   abort,
  output logic [PHASE_WIDTH-1:0] fre_word,
  output logic [PHASE_WIDTH-1:0] pha_word,
  output logic [1:0]             wave_type,
  output logic                   busy,
  output logic                   sweep_done
);

  sweep_state_e           state_q, state_d;
  logic [PHASE_WIDTH-1:0] start_q, start_d;
  logic [PHASE_WIDTH-1:0] stop_q, stop_d;
  logic [PHASE_WIDTH-1:0] step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   loop_q, loop_d;
  sweep_dir_e             dir_q, dir_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [PHASE_WIDTH-1:0] fre_word_q, fre_word_d;
  logic [PHASE_WIDTH-1:0] pha_word_q, pha_word_d;
  wave_e                  wave_type_q, wave_type_d;
  logic [PHASE_WIDTH-1:0] next_word;

  dds_step_calc #(
    .W (PHASE_WIDTH)
  ) u_step_calc (
    .cur_word  (fre_word_q),
    .step_word (step_q),
    .stop_word (stop_q),
    .dir       (dir_q),
    .next_word (next_word)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    loop_d      = loop_q;
    dir_d       = dir_q;
    dwell_cnt_d = dwell_cnt_q;
    fre_word_d  = fre_word_q;
    pha_word_d  = pha_word_q;
    wave_type_d = wave_type_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort is meaningless here; a simultaneous command still goes through.
        if (cfg_valid) begin
          start_d     = cfg_start_word;
          stop_d      = cfg_stop_word;
          step_d      = cfg_step_word;
          dwell_d     = cfg_dwell;
          loop_d      = cfg_loop;
          dir_d       = (cfg_stop_word >= cfg_start_word) ? DIR_UP : DIR_DOWN;
          dwell_cnt_d = cfg_dwell;
          fre_word_d  = cfg_start_word;
          pha_word_d  = cfg_pha_word;
          wave_type_d = wave_e'(cfg_wave_type);
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else if (fre_word_q != stop_q) begin
          fre_word_d  = next_word;
          dwell_cnt_d = dwell_q;
        end else if (loop_q) begin
          fre_word_d  = start_q;
          dwell_cnt_d = dwell_q;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Abort here changes nothing: the done pulse is already on the wire.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
      dir_q       <= DIR_UP;
      dwell_cnt_q <= '0;
      fre_word_q  <= '0;
      pha_word_q  <= '0;
      wave_type_q <= WAVE_SIN;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      loop_q      <= loop_d;
      dir_q       <= dir_d;
      dwell_cnt_q <= dwell_cnt_d;
      fre_word_q  <= fre_word_d;
      pha_word_q  <= pha_word_d;
      wave_type_q <= wave_type_d;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign sweep_done = (state_q == ST_DONE);
  assign fre_word   = fre_word_q;
  assign pha_word   = pha_word_q;
  assign wave_type  = wave_type_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: fixed sweeps with hand-computed point sequences.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start_word;
  logic [31:0] cfg_stop_word;
  logic [31:0] cfg_step_word;
  logic [23:0] cfg_dwell;
  logic [31:0] cfg_pha_word;
  logic [1:0]  cfg_wave_type;
  logic        cfg_loop;
  logic        abort;
  logic [31:0] fre_word;
  logic [31:0] pha_word;
  logic [1:0]  wave_type;
  logic        busy;
  logic        sweep_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_pts[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .PHASE_WIDTH (32),
    .DWELL_WIDTH (24)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_start_word (cfg_start_word),
    .cfg_stop_word  (cfg_stop_word),
    .cfg_step_word  (cfg_step_word),
    .cfg_dwell      (cfg_dwell),
    .cfg_pha_word   (cfg_pha_word),
    .cfg_wave_type  (cfg_wave_type),
    .cfg_loop       (cfg_loop),
    .abort          (abort),
    .fre_word       (fre_word),
    .pha_word       (pha_word),
    .wave_type      (wave_type),
    .busy           (busy),
    .sweep_done     (sweep_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] start, input logic [31:0] stop,
                      input logic [31:0] step, input logic [23:0] dwell,
                      input logic [31:0] pha, input logic [1:0] wave,
                      input logic lp, input logic ab);
    cfg_start_word = start;
    cfg_stop_word  = stop;
    cfg_step_word  = step;
    cfg_dwell      = dwell;
    cfg_pha_word   = pha;
    cfg_wave_type  = wave;
    cfg_loop       = lp;
    abort          = ab;
    cfg_valid      = 1'b1;
    tick;
    cfg_valid      = 1'b0;
    abort          = 1'b0;
  endtask

  // Each expected point must be visible for exactly dwell+1 samples.
  task automatic walk(input string tag, input int dwell);
    foreach (exp_pts[i]) begin
      for (int c = 0; c <= dwell; c++) begin
        chk({tag, "_fre"}, fre_word, exp_pts[i]);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_rdy"}, {31'b0, cfg_ready}, 32'd0);
        tick;
      end
    end
  endtask

  task automatic finish_done(input string tag, input logic [31:0] stop);
    chk({tag, "_done"}, {31'b0, sweep_done}, 32'd1);
    chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done_rdy"}, {31'b0, cfg_ready}, 32'd0);
    chk({tag, "_done_fre"}, fre_word, stop);
    tick;
    chk({tag, "_idle_done"}, {31'b0, sweep_done}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'b0, cfg_ready}, 32'd1);
    chk({tag, "_idle_fre"}, fre_word, stop);
  endtask

  initial begin
    rst_n          = 1'b0;
    cfg_valid      = 1'b0;
    cfg_start_word = '0;
    cfg_stop_word  = '0;
    cfg_step_word  = '0;
    cfg_dwell      = '0;
    cfg_pha_word   = '0;
    cfg_wave_type  = '0;
    cfg_loop       = 1'b0;
    abort          = 1'b0;
    tick;
    tick;
    chk("rst_fre", fre_word, 32'd0);
    chk("rst_pha", pha_word, 32'd0);
    chk("rst_wave", {30'b0, wave_type}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, sweep_done}, 32'd0);
    chk("rst_rdy", {31'b0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    tick;

    // Basic ascending sweep, three-cycle dwell.
    send(32'd1000, 32'd1300, 32'd100, 24'd2, 32'h0000_1234, 2'd2, 1'b0, 1'b0);
    chk("asc_pha", pha_word, 32'h0000_1234);
    chk("asc_wave", {30'b0, wave_type}, 32'd2);
    exp_pts = '{32'd1000, 32'd1100, 32'd1200, 32'd1300};
    walk("asc", 2);
    finish_done("asc", 32'd1300);
    chk("asc_hold_pha", pha_word, 32'h0000_1234);

    // Overshoot clamps to stop.
    send(32'd0, 32'd250, 32'd100, 24'd0, 32'd0, 2'd1, 1'b0, 1'b0);
    exp_pts = '{32'd0, 32'd100, 32'd200, 32'd250};
    walk("ovs", 0);
    finish_done("ovs", 32'd250);

    // Descending with undershoot clamp.
    send(32'd500, 32'd200, 32'd200, 24'd1, 32'd0, 2'd3, 1'b0, 1'b0);
    chk("dsc_wave", {30'b0, wave_type}, 32'd3);
    exp_pts = '{32'd500, 32'd300, 32'd200};
    walk("dsc", 1);
    finish_done("dsc", 32'd200);

    // Carry out of the top bit clamps to stop.
    send(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0200, 24'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    exp_pts = '{32'hFFFF_FF00, 32'hFFFF_FFFF};
    walk("carry", 0);
    finish_done("carry", 32'hFFFF_FFFF);

    // Single point held dwell+1 cycles; a command offered during RUN is ignored.
    send(32'd100, 32'd100, 32'd50, 24'd3, 32'd0, 2'd0, 1'b0, 1'b0);
    cfg_valid      = 1'b1;
    cfg_start_word = 32'd7;
    cfg_stop_word  = 32'd8;
    for (int c = 0; c <= 3; c++) begin
      chk("single_fre", fre_word, 32'd100);
      chk("single_busy", {31'b0, busy}, 32'd1);
      if (c == 3) cfg_valid = 1'b0;
      tick;
    end
    finish_done("single", 32'd100);

    // Looping sweep aborted on its second visit to 20.
    send(32'd10, 32'd30, 32'd10, 24'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    exp_pts = '{32'd10, 32'd20, 32'd30, 32'd10};
    walk("loop", 0);
    chk("loop_fre2", fre_word, 32'd20);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_rdy", {31'b0, cfg_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, sweep_done}, 32'd0);
    chk("abort_fre", fre_word, 32'd20);
    tick;
    chk("abort_done2", {31'b0, sweep_done}, 32'd0);
    chk("abort_fre2", fre_word, 32'd20);

    // Asynchronous reset mid-sweep.
    send(32'd1000, 32'd1300, 32'd100, 24'd2, 32'h0000_00AA, 2'd3, 1'b0, 1'b0);
    repeat (3) tick;
    chk("mid_fre", fre_word, 32'd1100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fre", fre_word, 32'd0);
    chk("arst_pha", pha_word, 32'd0);
    chk("arst_wave", {30'b0, wave_type}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_rdy", {31'b0, cfg_ready}, 32'd1);
    tick;
    rst_n = 1'b1;
    tick;

    // Zero step jumps to stop; abort alongside the command in IDLE is ignored.
    send(32'd5, 32'd9, 32'd0, 24'd0, 32'h0000_0077, 2'd1, 1'b0, 1'b1);
    chk("zstep_pha", pha_word, 32'h0000_0077);
    exp_pts = '{32'd5, 32'd9};
    walk("zstep", 0);
    finish_done("zstep", 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
